// File: rtl/pes_traffic_pkg.sv
// Shared types for the highway/farm traffic-light controller.
//  - Lamp encodings {R,Y,G} and the lamp-pair payload struct.
//  - State enum whose values double as the external phase code.
//  - decode_lights(): state (+ flash blink) to lamp pair.
package pes_traffic_pkg;

  localparam int unsigned LIGHT_W = 3;
  localparam int unsigned PHASE_W = 3;

  localparam logic [LIGHT_W-1:0] LIGHT_RED    = 3'b100;
  localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 3'b010;
  localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 3'b001;
  localparam logic [LIGHT_W-1:0] LIGHT_OFF    = 3'b000;

  typedef enum logic [PHASE_W-1:0] {
    ST_HG    = 3'd0,
    ST_HY    = 3'd1,
    ST_AR1   = 3'd2,
    ST_FG    = 3'd3,
    ST_FY    = 3'd4,
    ST_AR2   = 3'd5,
    ST_FLASH = 3'd6
  } state_e;

  typedef struct packed {
    logic [LIGHT_W-1:0] hw;
    logic [LIGHT_W-1:0] farm;
  } lights_t;

  // Lamp pair for a state; anything not explicitly lit stays RED.
  function automatic lights_t decode_lights(input state_e st, input logic blink);
    lights_t l;
    l.hw   = LIGHT_RED;
    l.farm = LIGHT_RED;
    case (st)
      ST_HG:    l.hw   = LIGHT_GREEN;
      ST_HY:    l.hw   = LIGHT_YELLOW;
      ST_FG:    l.farm = LIGHT_GREEN;
      ST_FY:    l.farm = LIGHT_YELLOW;
      ST_FLASH: begin
        l.hw   = blink ? LIGHT_YELLOW : LIGHT_OFF;
        l.farm = blink ? LIGHT_YELLOW : LIGHT_OFF;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/pes_sensor_debounce.sv
// Farm sensor conditioning: 2-FF synchroniser followed by a debounce counter.
//  clk, rst_n : clock, async active-low reset
//  din        : raw asynchronous sensor
//  dout       : debounced level; changes after DEB_CYC consecutive synchronised
//               samples that differ from the current dout
module pes_sensor_debounce
  import pes_traffic_pkg::*;
#(
  parameter int unsigned DEB_CYC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned DCNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYC - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              dout_q, dout_d;
  logic [DCNT_W-1:0] cnt_q, cnt_d;

  if (DEB_CYC == 0) begin : g_bad_deb_cyc
    $error("DEB_CYC must be at least 1");
  end

  // Count samples disagreeing with dout; any agreeing sample restarts the count.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    dout_d  = dout_q;
    cnt_d   = '0;
    if (sync2_q != dout_q) begin
      if (cnt_q == DCNT_LAST) begin
        dout_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/pes_traffic_ctrl_p.sv
// Highway/farm-road traffic-light controller with timed phases, all-red
// clearance and a night flash mode.
//  clk, rst_n     : clock, async active-low reset
//  sensor         : raw farm-road vehicle sensor (asynchronous)
//  flash_en       : night flash request (synchronous)
//  light_highway  : {R,Y,G} highway lamps, registered
//  light_farm     : {R,Y,G} farm lamps, registered
//  phase          : current state code, registered
module pes_traffic_ctrl_p
  import pes_traffic_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned T_HG_MIN = 16,
  parameter int unsigned T_Y      = 4,
  parameter int unsigned T_AR     = 2,
  parameter int unsigned T_FG_MAX = 12,
  parameter int unsigned DEB_CYC  = 3,
  parameter int unsigned T_FLASH  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sensor,
  input  logic               flash_en,
  output logic [LIGHT_W-1:0] light_highway,
  output logic [LIGHT_W-1:0] light_farm,
  output logic [PHASE_W-1:0] phase
);

  localparam longint unsigned T_LIM = 64'd1 << CNT_W;

  // Timer value seen on the last cycle of a phase of length T.
  localparam logic [CNT_W-1:0] HG_MIN_LAST = CNT_W'(T_HG_MIN - 1);
  localparam logic [CNT_W-1:0] Y_LAST      = CNT_W'(T_Y - 1);
  localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(T_AR - 1);
  localparam logic [CNT_W-1:0] FG_LAST     = CNT_W'(T_FG_MAX - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(T_FLASH - 1);

  if (CNT_W == 0 || CNT_W > 32) begin : g_bad_cnt_w
    $error("CNT_W must be in 1..32");
  end
  if (T_HG_MIN == 0 || 64'(T_HG_MIN) >= T_LIM) begin : g_bad_t_hg_min
    $error("T_HG_MIN out of range");
  end
  if (T_Y == 0 || 64'(T_Y) >= T_LIM) begin : g_bad_t_y
    $error("T_Y out of range");
  end
  if (T_AR == 0 || 64'(T_AR) >= T_LIM) begin : g_bad_t_ar
    $error("T_AR out of range");
  end
  if (T_FG_MAX == 0 || 64'(T_FG_MAX) >= T_LIM) begin : g_bad_t_fg_max
    $error("T_FG_MAX out of range");
  end
  if (T_FLASH == 0 || 64'(T_FLASH) >= T_LIM) begin : g_bad_t_flash
    $error("T_FLASH out of range");
  end

  logic             sensor_db;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             blink_q, blink_d;
  lights_t          lights_q, lights_d;

  pes_sensor_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sensor),
    .dout  (sensor_db)
  );

  // Next state, phase timer, blink and lamp decode of the next state.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bcnt_d   = bcnt_q;
    blink_d  = blink_q;
    lights_d = lights_q;

    case (state_q)
      ST_HG: begin
        if (flash_en) begin
          state_d = ST_HY;
        end else if (sensor_db && (timer_q >= HG_MIN_LAST)) begin
          state_d = ST_HY;
        end
      end
      ST_HY:  if (timer_q == Y_LAST)  state_d = ST_AR1;
      ST_AR1: if (timer_q == AR_LAST) state_d = flash_en ? ST_FLASH : ST_FG;
      ST_FG: begin
        if (flash_en || !sensor_db || (timer_q == FG_LAST)) begin
          state_d = ST_FY;
        end
      end
      ST_FY:    if (timer_q == Y_LAST)  state_d = ST_AR2;
      ST_AR2:   if (timer_q == AR_LAST) state_d = flash_en ? ST_FLASH : ST_HG;
      ST_FLASH: if (!flash_en)          state_d = ST_AR2;
      default:  state_d = ST_HG;
    endcase

    // Timer restarts on every state change and saturates at all-ones.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + CNT_W'(1);
    end

    // Blink starts lit on FLASH entry and toggles every T_FLASH cycles.
    if (state_d == ST_FLASH) begin
      if (state_q != ST_FLASH) begin
        blink_d = 1'b1;
        bcnt_d  = '0;
      end else if (bcnt_q == FLASH_LAST) begin
        blink_d = ~blink_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + CNT_W'(1);
      end
    end else begin
      bcnt_d = '0;
    end

    lights_d = decode_lights(state_d, blink_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_HG;
      timer_q  <= '0;
      bcnt_q   <= '0;
      blink_q  <= 1'b1;
      lights_q <= '{hw: LIGHT_GREEN, farm: LIGHT_RED};
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bcnt_q   <= bcnt_d;
      blink_q  <= blink_d;
      lights_q <= lights_d;
    end
  end

  assign light_highway = lights_q.hw;
  assign light_farm    = lights_q.farm;
  assign phase         = PHASE_W'(state_q);

endmodule

// File: tb/tb_pes_traffic_ctrl_p.sv
// Bench for pes_traffic_ctrl_p (default parameters).
// Cycle n is observed on the falling edge before rising edge n, so cycle 0
// shows the reset state; inputs driven in cycle n are captured by edge n.
module tb_pes_traffic_ctrl_p;
  import pes_traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sensor;
  logic       flash_en;
  logic [2:0] light_highway;
  logic [2:0] light_farm;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  pes_traffic_ctrl_p dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sensor        (sensor),
    .flash_en      (flash_en),
    .light_highway (light_highway),
    .light_farm    (light_farm),
    .phase         (phase)
  );

  typedef struct {
    string      name;
    bit         do_rst;
    int         len;
    bit         s;
    bit         f;
    logic [2:0] hw;
    logic [2:0] farm;
    logic [2:0] ph;
  } seg_t;

  seg_t segs[$];

  function automatic void add(input string name, input bit do_rst, input int len,
                              input bit s, input bit f, input logic [2:0] hw,
                              input logic [2:0] farm, input logic [2:0] ph);
    seg_t sg;
    sg.name = name; sg.do_rst = do_rst; sg.len = len; sg.s = s; sg.f = f;
    sg.hw = hw; sg.farm = farm; sg.ph = ph;
    segs.push_back(sg);
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // Outside FLASH at least one road must show RED.
  task automatic chk_safe();
    n_tests++;
    if (phase !== 3'd6 && light_highway !== LIGHT_RED && light_farm !== LIGHT_RED) begin
      n_fail++;
      $display("FAIL safety cycle %0d: got hw=%b farm=%b phase=%0d, expected one road RED",
               cyc, light_highway, light_farm, phase);
    end
  endtask

  task automatic chk_all(input string name, input logic [2:0] hw, input logic [2:0] farm,
                         input logic [2:0] ph);
    chk({name, ".hw"}, light_highway, hw);
    chk({name, ".farm"}, light_farm, farm);
    chk({name, ".phase"}, phase, ph);
    chk_safe();
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    sensor   = 1'b0;
    flash_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    // t1: no traffic keeps the highway green
    add("t1", 1'b1, 200, 1'b0, 1'b0, LIGHT_GREEN, LIGHT_RED, 3'd0);
    // t2: sensor held from cycle 0, full cycle with farm green capped at max
    add("t2_hg",  1'b1, 16, 1'b1, 1'b0, LIGHT_GREEN,  LIGHT_RED,    3'd0);
    add("t2_hy",  1'b0,  4, 1'b1, 1'b0, LIGHT_YELLOW, LIGHT_RED,    3'd1);
    add("t2_ar1", 1'b0,  2, 1'b1, 1'b0, LIGHT_RED,    LIGHT_RED,    3'd2);
    add("t2_fg",  1'b0, 12, 1'b1, 1'b0, LIGHT_RED,    LIGHT_GREEN,  3'd3);
    add("t2_fy",  1'b0,  4, 1'b1, 1'b0, LIGHT_RED,    LIGHT_YELLOW, 3'd4);
    add("t2_ar2", 1'b0,  2, 1'b1, 1'b0, LIGHT_RED,    LIGHT_RED,    3'd5);
    add("t2_hg2", 1'b0,  1, 1'b1, 1'b0, LIGHT_GREEN,  LIGHT_RED,    3'd0);
    // t5: flash request at cycle 5 preempts min green
    add("t5_hg",   1'b1, 5, 1'b0, 1'b0, LIGHT_GREEN,  LIGHT_RED,    3'd0);
    add("t5_req",  1'b0, 1, 1'b0, 1'b1, LIGHT_GREEN,  LIGHT_RED,    3'd0);
    add("t5_hy",   1'b0, 4, 1'b0, 1'b1, LIGHT_YELLOW, LIGHT_RED,    3'd1);
    add("t5_ar1",  1'b0, 2, 1'b0, 1'b1, LIGHT_RED,    LIGHT_RED,    3'd2);
    add("t5_on1",  1'b0, 8, 1'b0, 1'b1, LIGHT_YELLOW, LIGHT_YELLOW, 3'd6);
    add("t5_off1", 1'b0, 8, 1'b0, 1'b1, LIGHT_OFF,    LIGHT_OFF,    3'd6);
    add("t5_on2",  1'b0, 8, 1'b0, 1'b1, LIGHT_YELLOW, LIGHT_YELLOW, 3'd6);
    add("t5_drop", 1'b0, 1, 1'b0, 1'b0, LIGHT_OFF,    LIGHT_OFF,    3'd6);
    add("t5_ar2",  1'b0, 2, 1'b0, 1'b0, LIGHT_RED,    LIGHT_RED,    3'd5);
    add("t5_hg2",  1'b0, 1, 1'b0, 1'b0, LIGHT_GREEN,  LIGHT_RED,    3'd0);

    foreach (segs[i]) begin
      if (segs[i].do_rst) do_reset();
      for (int k = 0; k < segs[i].len; k++) begin
        sensor   = segs[i].s;
        flash_en = segs[i].f;
        chk_all(segs[i].name, segs[i].hw, segs[i].farm, segs[i].ph);
        next_cycle();
      end
    end

    // t3: 2-cycle glitch ignored; held sensor reaches the FSM after
    // sync (2) + debounce (3) + state register (1) cycles.
    do_reset();
    while (cyc < 30) next_cycle();
    for (int k = 30; k < 50; k++) begin
      sensor = (k < 32);
      chk("t3_glitch.phase", phase, 3'd0);
      chk_safe();
      next_cycle();
    end
    sensor = 1'b1;
    for (int k = 50; k < 56; k++) begin
      chk("t3_wait.phase", phase, 3'd0);
      next_cycle();
    end
    chk_all("t3_hy", LIGHT_YELLOW, LIGHT_RED, 3'd1);

    // t4: sensor drops at cycle 25 during farm green, cutting it to 9 cycles
    do_reset();
    sensor = 1'b1;
    while (cyc < 25) next_cycle();
    chk_all("t4_fg_before", LIGHT_RED, LIGHT_GREEN, 3'd3);
    sensor = 1'b0;
    while (cyc < 30) next_cycle();
    chk_all("t4_fg_last", LIGHT_RED, LIGHT_GREEN, 3'd3);
    next_cycle();
    chk_all("t4_fy", LIGHT_RED, LIGHT_YELLOW, 3'd4);
    while (cyc < 35) next_cycle();
    chk_all("t4_ar2", LIGHT_RED, LIGHT_RED, 3'd5);
    while (cyc < 37) next_cycle();
    chk_all("t4_hg", LIGHT_GREEN, LIGHT_RED, 3'd0);

    // t6: async reset in the middle of farm yellow
    do_reset();
    sensor = 1'b1;
    while (cyc < 35) next_cycle();
    chk_all("t6_fy", LIGHT_RED, LIGHT_YELLOW, 3'd4);
    rst_n = 1'b0;
    #1;
    chk_all("t6_rst", LIGHT_GREEN, LIGHT_RED, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 16; k++) begin
      chk("t6_restart.phase", phase, 3'd0);
      next_cycle();
    end
    chk_all("t6_hy", LIGHT_YELLOW, LIGHT_RED, 3'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
